// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-requester SPI transaction arbiter.
// Holds the controller state encoding and the default timeout length.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

    typedef logic [15:0] cmd_t;
    typedef logic [7:0]  data_t;

    localparam logic [15:0] TO_CYC_DEF = 16'd4095;

endpackage

// File: rtl/spi_arb_if.sv
// Requester-side and spi_master-side signals of the arbiter, bundled as one port.
// slave = arbiter view, master = environment (requesters + spi_master) view.
interface spi_arb_if;
    import spi_arb_pkg::*;

    logic  req0, req1;
    cmd_t  cmd0, cmd1;
    logic  lock0, lock1;
    logic  gnt0, gnt1;
    logic  done0, done1;
    data_t rd_data;
    logic  to_err;
    logic  spi_wrt;
    cmd_t  spi_cmd;
    logic  spi_done;
    data_t spi_rd_data;
    logic  busy;

    modport slave (
        input  req0, req1, cmd0, cmd1, lock0, lock1, spi_done, spi_rd_data,
        output gnt0, gnt1, done0, done1, rd_data, to_err, spi_wrt, spi_cmd, busy
    );

    modport master (
        output req0, req1, cmd0, cmd1, lock0, lock1, spi_done, spi_rd_data,
        input  gnt0, gnt1, done0, done1, rd_data, to_err, spi_wrt, spi_cmd, busy
    );

endinterface

// File: rtl/spi_arb.sv
// Round-robin arbiter with owner lock and timeout in front of one spi_master.
// gnt/spi_wrt one cycle after req is sampled in IDLE; done one cycle after spi_done.
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter logic [15:0] TO_CYC = TO_CYC_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    spi_arb_if.slave bus
);

    state_t      state_q, state_d;
    cmd_t        cmd_q, cmd_d;
    data_t       rd_data_q, rd_data_d;
    logic [15:0] cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        hold_q, hold_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic        wrt_q, wrt_d;
    logic        to_err_q, to_err_d;

    logic [1:0]  req;
    logic [1:0]  lock;
    logic        win;
    logic        go;

    assign req  = {bus.req1, bus.req0};
    assign lock = {bus.lock1, bus.lock0};

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        rd_data_d = rd_data_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        hold_d    = hold_q;
        gnt_d     = 2'b00;
        done_d    = 2'b00;
        wrt_d     = 1'b0;
        to_err_d  = 1'b0;
        win       = 1'b0;
        go        = 1'b0;
        case (state_q)
            IDLE: begin
                if (hold_q && !lock[last_q]) begin
                    hold_d = 1'b0;
                end
                // A locked owner excludes the other requester whatever the pointer says.
                if (hold_q && lock[last_q]) begin
                    go  = req[last_q];
                    win = last_q;
                end else if (req[0] && req[1]) begin
                    go  = 1'b1;
                    win = ~last_q;
                end else if (req != 2'b00) begin
                    go  = 1'b1;
                    win = req[1];
                end
                if (go) begin
                    owner_d    = win;
                    cmd_d      = win ? bus.cmd1 : bus.cmd0;
                    gnt_d[win] = 1'b1;
                    wrt_d      = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 16'd0;
                state_d = BUSY;
            end
            BUSY: begin
                if (bus.spi_done) begin
                    rd_data_d       = bus.spi_rd_data;
                    done_d[owner_q] = 1'b1;
                    last_d          = owner_q;
                    hold_d          = lock[owner_q];
                    state_d         = IDLE;
                end else if (cnt_q == TO_CYC) begin
                    rd_data_d       = 8'hFF;
                    done_d[owner_q] = 1'b1;
                    to_err_d        = 1'b1;
                    hold_d          = 1'b0;
                    state_d         = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_q resets to 1 so that requester 0 wins the first contested round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_q     <= 16'h0000;
            rd_data_q <= 8'h00;
            cnt_q     <= 16'd0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            hold_q    <= 1'b0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            wrt_q     <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            rd_data_q <= rd_data_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            wrt_q     <= wrt_d;
            to_err_q  <= to_err_d;
        end
    end

    assign bus.gnt0    = gnt_q[0];
    assign bus.gnt1    = gnt_q[1];
    assign bus.done0   = done_q[0];
    assign bus.done1   = done_q[1];
    assign bus.rd_data = rd_data_q;
    assign bus.to_err  = to_err_q;
    assign bus.spi_wrt = wrt_q;
    assign bus.spi_cmd = cmd_q;
    assign bus.busy    = (state_q != IDLE);

endmodule
